// File: rtl/regbank_arbiter.sv
// regbank_arbiter
// Round-robin arbiter and sequencer for a bank of 1-bit registers shared by
// NREQ requesters. One transaction (single-bit read or write) is performed
// at a time using IDLE -> ACCESS -> DONE, i.e. at most one per 3 cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-low reset
//   req    per-requester request level
//   we     per-requester write enable (1 = write, 0 = read)
//   addr   packed addresses, requester i uses addr[i*AW +: AW]
//   wdata  per-requester write data bit
//   gnt    one-hot grant, high only in ACCESS
//   ack    one-hot completion pulse, high only in DONE
//   rdata  read data from the last completed read
//   q      current register bank contents
//   busy   high whenever the FSM is not IDLE
module regbank_arbiter #(
   parameter int NREQ  = 4,
   parameter int NREGS = 8,
   parameter int AW    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       we,
   input  logic [NREQ*AW-1:0]    addr,
   input  logic [NREQ-1:0]       wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  rdata,
   output logic [NREGS-1:0]      q,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state, state_nxt;

   // Transaction latched at selection time; only these drive the access.
   logic [IW-1:0]    win_idx;
   logic             we_l;
   logic [AW-1:0]    addr_l;
   logic             wdata_l;
   logic [IW-1:0]    last_winner;

   // Round-robin search results
   logic             rr_found;
   logic [IW-1:0]    rr_pick;
   int unsigned      rr_cand;

   // Fields of the selected requester
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic             sel_wdata;

   // Bank access decode
   logic             bank_bit;
   logic [NREGS-1:0] q_wr;

   // ------------------------------------------------------------------
   // Round-robin: walk offsets 1..NREQ from last_winner, first hit wins.
   // ------------------------------------------------------------------
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = last_winner;
      rr_cand  = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         rr_cand = 32'(last_winner) + off;
         if (rr_cand >= NREQ) begin
            rr_cand = rr_cand - NREQ;
         end
         if (!rr_found && |(req & (NREQ'(1) << rr_cand))) begin
            rr_found = 1'b1;
            rr_pick  = IW'(rr_cand);
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (rr_pick == IW'(j)) begin
            sel_we    = we[j];
            sel_addr  = addr[j*AW +: AW];
            sel_wdata = wdata[j];
         end
      end
   end

   // Address decode by comparison so out-of-range addresses simply match
   // nothing: reads return 0 and writes leave the bank unchanged.
   always_comb begin
      bank_bit = 1'b0;
      q_wr     = q;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (addr_l == AW'(i)) begin
            bank_bit = q[i];
            q_wr[i]  = wdata_l;
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      gnt       = '0;
      ack       = '0;
      case (state)
         IDLE: begin
            if (rr_found) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            gnt[win_idx] = 1'b1;
            state_nxt    = DONE;
         end
         DONE: begin
            ack[win_idx] = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // ------------------------------------------------------------------
   // State register and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         win_idx     <= '0;
         we_l        <= 1'b0;
         addr_l      <= '0;
         wdata_l     <= 1'b0;
         last_winner <= IW'(NREQ - 1);
         rdata       <= 1'b0;
         q           <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (rr_found) begin
                  win_idx <= rr_pick;
                  we_l    <= sel_we;
                  addr_l  <= sel_addr;
                  wdata_l <= sel_wdata;
               end
            end
            ACCESS: begin
               if (we_l) begin
                  q <= q_wr;
               end else begin
                  rdata <= bank_bit;
               end
               last_winner <= win_idx;
            end
            default: ;
         endcase
      end
   end

endmodule
